// File: rtl/cmp_result_debouncer_if.sv
// Bundle of comparator flags in and committed decision out for cmp_result_debouncer.
// The bench or the upstream block drives the master side; the debouncer is the slave.
interface cmp_result_debouncer_if #(
  parameter int CNT_W = 8
);
  logic             clr;
  logic             in_valid;
  logic             a_gt_b;
  logic             a_eq_b;
  logic             a_lt_b;
  logic             out_valid;
  logic             gt_q;
  logic             eq_q;
  logic             lt_q;
  logic             change_pulse;
  logic [CNT_W-1:0] change_count;
  logic             err;

  modport master (
    output clr, in_valid, a_gt_b, a_eq_b, a_lt_b,
    input  out_valid, gt_q, eq_q, lt_q, change_pulse, change_count, err
  );

  modport slave (
    input  clr, in_valid, a_gt_b, a_eq_b, a_lt_b,
    output out_valid, gt_q, eq_q, lt_q, change_pulse, change_count, err
  );
endinterface

// File: rtl/cmp_result_debouncer.sv
// Debounces one-hot comparator flags: commits a result after STABLE_CNT identical
// valid samples, pulses and counts committed changes, and flags illegal patterns.
module cmp_result_debouncer #(
  parameter int STABLE_CNT = 4,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  cmp_result_debouncer_if.slave bus
);
  localparam int               RUN_W   = $clog2(STABLE_CNT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {IDLE = 1'b0, STABLE = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [2:0]       cand_p0;
  logic [RUN_W-1:0] run_p0;
  logic [2:0]       res_p0;
  logic             pulse_p0;
  logic             err_p0;
  logic [CNT_W-1:0] count_p0;

  logic [2:0]       sample;
  logic             onehot;
  logic             accept;
  logic             illegal;
  logic [RUN_W-1:0] run_nxt;
  logic             commit;
  logic             change;

  function automatic logic [RUN_W-1:0] run_sat_inc(input logic [RUN_W-1:0] r);
    return (r == RUN_MAX) ? r : r + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] count_sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  assign sample  = {bus.a_gt_b, bus.a_eq_b, bus.a_lt_b};
  assign onehot  = (sample == 3'b100) || (sample == 3'b010) || (sample == 3'b001);
  assign accept  = bus.in_valid & onehot;
  assign illegal = bus.in_valid & ~onehot;
  // A "none" candidate (3'b000) never matches a legal sample, so a new run starts at 1.
  assign run_nxt = (sample == cand_p0) ? run_sat_inc(run_p0) : RUN_W'(1);
  assign commit  = accept && (run_nxt == RUN_MAX) && ((state == IDLE) || (sample != res_p0));
  assign change  = commit && (state == STABLE);

  // Stage p0: run tracking, committed result and event registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_p0  <= '0;
      run_p0   <= '0;
      res_p0   <= '0;
      pulse_p0 <= 1'b0;
      err_p0   <= 1'b0;
      count_p0 <= '0;
    end else if (bus.clr) begin
      cand_p0  <= '0;
      run_p0   <= '0;
      res_p0   <= '0;
      pulse_p0 <= 1'b0;
      err_p0   <= 1'b0;
      count_p0 <= '0;
    end else begin
      pulse_p0 <= change;
      err_p0   <= illegal;
      if (illegal) begin
        cand_p0 <= '0;
        run_p0  <= '0;
      end else if (accept) begin
        cand_p0 <= sample;
        run_p0  <= run_nxt;
      end
      if (commit) res_p0 <= sample;
      if (change) count_p0 <= count_sat_inc(count_p0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.clr)     state_nxt = IDLE;
    else if (commit) state_nxt = STABLE;
  end

  always_comb begin
    bus.out_valid    = (state == STABLE);
    bus.gt_q         = res_p0[2] & (state == STABLE);
    bus.eq_q         = res_p0[1] & (state == STABLE);
    bus.lt_q         = res_p0[0] & (state == STABLE);
    bus.change_pulse = pulse_p0;
    bus.change_count = count_p0;
    bus.err          = err_p0;
  end
endmodule

// File: tb/tb_cmp_result_debouncer.sv
// Directed bench for cmp_result_debouncer: a default instance plus a CNT_W=2
// instance fed the same stimulus to exercise change_count saturation.
module tb_cmp_result_debouncer;
  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] LT = 3'b001;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  cmp_result_debouncer_if #(.CNT_W(8)) bus  ();
  cmp_result_debouncer_if #(.CNT_W(2)) bus2 ();

  cmp_result_debouncer #(.STABLE_CNT(4), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  cmp_result_debouncer #(.STABLE_CNT(4), .CNT_W(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  // {out_valid, gt_q, eq_q, lt_q, change_pulse, err}
  logic [5:0] st;
  logic [5:0] st2;
  assign st  = {bus.out_valid, bus.gt_q, bus.eq_q, bus.lt_q, bus.change_pulse, bus.err};
  assign st2 = {bus2.out_valid, bus2.gt_q, bus2.eq_q, bus2.lt_q, bus2.change_pulse, bus2.err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic smp(input logic v, input logic [2:0] f, input logic c);
    bus.in_valid  = v;
    bus2.in_valid = v;
    bus.clr       = c;
    bus2.clr      = c;
    {bus.a_gt_b, bus.a_eq_b, bus.a_lt_b}    = f;
    {bus2.a_gt_b, bus2.a_eq_b, bus2.a_lt_b} = f;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    smp(1'b0, 3'b000, 1'b0);
    rst = 1'b0;
    smp(1'b0, 3'b000, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.clr = 1'b0; bus2.clr = 1'b0;
    bus.in_valid = 1'b0; bus2.in_valid = 1'b0;
    {bus.a_gt_b, bus.a_eq_b, bus.a_lt_b}    = 3'b000;
    {bus2.a_gt_b, bus2.a_eq_b, bus2.a_lt_b} = 3'b000;
    #12;
    checks++;
    if (st !== 6'b000000) begin errors++; $display("FAIL reset_flags got %b exp %b", st, 6'b000000); end
    checks++;
    if (bus.change_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.change_count); end
    @(posedge clk); #1;
    rst = 1'b0;
    smp(1'b0, 3'b000, 1'b0);
  endtask

  task automatic test_first_commit();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      smp(1'b1, GT, 1'b0);
      checks++;
      if (st !== 6'b000000) begin errors++; $display("FAIL first_commit_early[%0d] got %b exp %b", i, st, 6'b000000); end
    end
    smp(1'b1, GT, 1'b0);
    checks++;
    if (st !== 6'b110000) begin errors++; $display("FAIL first_commit got %b exp %b", st, 6'b110000); end
    checks++;
    if (bus.change_count !== 8'd0) begin errors++; $display("FAIL first_commit_count got %0d exp 0", bus.change_count); end
  endtask

  task automatic test_change();
    logic [2:0] seq [7];
    seq = '{EQ, EQ, EQ, GT, EQ, EQ, EQ};
    for (int i = 0; i < 7; i++) begin
      smp(1'b1, seq[i], 1'b0);
      checks++;
      if (st !== 6'b110000) begin errors++; $display("FAIL change_hold[%0d] got %b exp %b", i, st, 6'b110000); end
    end
    smp(1'b1, EQ, 1'b0);
    checks++;
    if (st !== 6'b101010) begin errors++; $display("FAIL change_commit got %b exp %b", st, 6'b101010); end
    checks++;
    if (bus.change_count !== 8'd1) begin errors++; $display("FAIL change_count got %0d exp 1", bus.change_count); end
    smp(1'b0, 3'b000, 1'b0);
    checks++;
    if (st !== 6'b101000) begin errors++; $display("FAIL change_pulse_end got %b exp %b", st, 6'b101000); end
  endtask

  task automatic test_requalify();
    for (int i = 0; i < 5; i++) begin
      smp(1'b1, EQ, 1'b0);
      checks++;
      if (st !== 6'b101000 || bus.change_count !== 8'd1) begin
        errors++; $display("FAIL requalify[%0d] got %b/%0d exp %b/1", i, st, bus.change_count, 6'b101000);
      end
    end
  endtask

  task automatic test_gaps();
    do_reset();
    smp(1'b1, GT, 1'b0);
    smp(1'b1, GT, 1'b0);
    for (int i = 0; i < 5; i++) smp(1'b0, EQ, 1'b0);
    smp(1'b1, GT, 1'b0);
    checks++;
    if (st !== 6'b000000) begin errors++; $display("FAIL gaps_early got %b exp %b", st, 6'b000000); end
    smp(1'b1, GT, 1'b0);
    checks++;
    if (st !== 6'b110000) begin errors++; $display("FAIL gaps_commit got %b exp %b", st, 6'b110000); end
  endtask

  task automatic test_illegal();
    do_reset();
    for (int i = 0; i < 3; i++) smp(1'b1, GT, 1'b0);
    smp(1'b1, 3'b110, 1'b0);
    checks++;
    if (st !== 6'b000001) begin errors++; $display("FAIL illegal_err got %b exp %b", st, 6'b000001); end
    smp(1'b0, 3'b000, 1'b0);
    checks++;
    if (st !== 6'b000000) begin errors++; $display("FAIL illegal_err_end got %b exp %b", st, 6'b000000); end
    for (int i = 0; i < 3; i++) begin
      smp(1'b1, GT, 1'b0);
      checks++;
      if (st !== 6'b000000) begin errors++; $display("FAIL illegal_restart[%0d] got %b exp %b", i, st, 6'b000000); end
    end
    smp(1'b1, GT, 1'b0);
    checks++;
    if (st !== 6'b110000) begin errors++; $display("FAIL illegal_recommit got %b exp %b", st, 6'b110000); end
    smp(1'b1, 3'b000, 1'b0);
    checks++;
    if (st !== 6'b110001) begin errors++; $display("FAIL illegal_hold_000 got %b exp %b", st, 6'b110001); end
    smp(1'b1, 3'b111, 1'b0);
    checks++;
    if (st !== 6'b110001) begin errors++; $display("FAIL illegal_hold_111 got %b exp %b", st, 6'b110001); end
    for (int i = 0; i < 4; i++) smp(1'b1, EQ, 1'b0);
    checks++;
    if (st !== 6'b101010 || bus.change_count !== 8'd1) begin
      errors++; $display("FAIL illegal_then_change got %b/%0d exp %b/1", st, bus.change_count, 6'b101010);
    end
  endtask

  task automatic test_saturate();
    int exp2;
    do_reset();
    for (int r = 0; r < 7; r++) begin
      for (int k = 0; k < 4; k++) smp(1'b1, (r % 2 == 0) ? LT : GT, 1'b0);
      exp2 = (r > 3) ? 3 : r;
      checks++;
      if (bus2.change_count !== 2'(exp2)) begin
        errors++; $display("FAIL sat_count2[%0d] got %0d exp %0d", r, bus2.change_count, exp2);
      end
      checks++;
      if (bus.change_count !== 8'(r)) begin
        errors++; $display("FAIL sat_count8[%0d] got %0d exp %0d", r, bus.change_count, r);
      end
      checks++;
      if (bus2.change_pulse !== (r > 0)) begin
        errors++; $display("FAIL sat_pulse[%0d] got %b exp %b", r, bus2.change_pulse, (r > 0));
      end
    end
    checks++;
    if (st2 !== 6'b100110) begin errors++; $display("FAIL sat_final got %b exp %b", st2, 6'b100110); end
  endtask

  task automatic test_clr_and_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) smp(1'b1, GT, 1'b0);
    smp(1'b1, GT, 1'b1);
    checks++;
    if (st !== 6'b000000) begin errors++; $display("FAIL clr_block got %b exp %b", st, 6'b000000); end
    for (int i = 0; i < 3; i++) smp(1'b1, GT, 1'b0);
    checks++;
    if (st !== 6'b000000) begin errors++; $display("FAIL clr_run_reset got %b exp %b", st, 6'b000000); end
    smp(1'b1, GT, 1'b0);
    checks++;
    if (st !== 6'b110000) begin errors++; $display("FAIL clr_recommit got %b exp %b", st, 6'b110000); end
    for (int i = 0; i < 4; i++) smp(1'b1, EQ, 1'b0);
    smp(1'b0, 3'b000, 1'b1);
    checks++;
    if (st !== 6'b000000 || bus.change_count !== 8'd0) begin
      errors++; $display("FAIL clr_clear got %b/%0d exp %b/0", st, bus.change_count, 6'b000000);
    end
    for (int i = 0; i < 4; i++) smp(1'b1, LT, 1'b0);
    checks++;
    if (st !== 6'b100100) begin errors++; $display("FAIL pre_async got %b exp %b", st, 6'b100100); end
    bus.in_valid = 1'b0; bus2.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (st !== 6'b000000) begin errors++; $display("FAIL async_rst got %b exp %b", st, 6'b000000); end
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    smp(1'b1, LT, 1'b0);
    checks++;
    if (st !== 6'b000000) begin errors++; $display("FAIL async_rst_run got %b exp %b", st, 6'b000000); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_first_commit();
    test_change();
    test_requalify();
    test_gaps();
    test_illegal();
    test_saturate();
    test_clr_and_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
